// File: rtl/wb_arbiter_2mst_to_1slv.sv
// wb_arbiter_2mst_to_1slv
// Round-robin Wishbone arbiter that lets two masters (m0, m1) share one slave.
// The grant is registered and held for the whole bus cycle (while the granted
// master keeps cyc high). Block transfers are therefore never split. Every
// release passes through IDLE for one turnaround cycle.
//
// Optional feature, compile-time macro WB_ARB_TIMEOUT_EN:
//   A watchdog counts slave wait cycles. On the (2^TIMEOUT_W-1)th wait cycle it
//   terminates the access: the master gets ack with TIMEOUT_DATA, the slave
//   sees stb=0, and the sticky timeout_o flag is set.
//   Without the macro no counter is built and timeout_o is tied to 0.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   wbs_m{0,1}_cyc/stb/we/adr/dat/sel_i  master request buses
//   wbs_m{0,1}_dat_o / ack_o         master return path (granted master only)
//   wbs_s_cyc/stb/we/adr/dat/sel_o   slave request bus (granted master's signals)
//   wbs_s_dat_i / wbs_s_ack_i        slave return path
//   grant_o                          one-hot current grant, 00 when idle
//   timeout_o                        sticky watchdog flag
module wb_arbiter_2mst_to_1slv #(
  parameter int          TIMEOUT_W    = 8,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_0BAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_m0_cyc_i,
  input  logic        wbs_m0_stb_i,
  input  logic        wbs_m0_we_i,
  input  logic [31:0] wbs_m0_adr_i,
  input  logic [31:0] wbs_m0_dat_i,
  input  logic [3:0]  wbs_m0_sel_i,
  output logic [31:0] wbs_m0_dat_o,
  output logic        wbs_m0_ack_o,
  input  logic        wbs_m1_cyc_i,
  input  logic        wbs_m1_stb_i,
  input  logic        wbs_m1_we_i,
  input  logic [31:0] wbs_m1_adr_i,
  input  logic [31:0] wbs_m1_dat_i,
  input  logic [3:0]  wbs_m1_sel_i,
  output logic [31:0] wbs_m1_dat_o,
  output logic        wbs_m1_ack_o,
  output logic        wbs_s_cyc_o,
  output logic        wbs_s_stb_o,
  output logic        wbs_s_we_o,
  output logic [31:0] wbs_s_adr_o,
  output logic [31:0] wbs_s_dat_o,
  output logic [3:0]  wbs_s_sel_o,
  input  logic [31:0] wbs_s_dat_i,
  input  logic        wbs_s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_q;   // master granted most recently; the other wins a tie

  logic req0, req1;
  logic sel0, sel1;
  logic gstb;           // stb of the granted master, before watchdog masking
  logic fire;           // watchdog terminates the current access this cycle

  assign req0 = wbs_m0_cyc_i & wbs_m0_stb_i;
  assign req1 = wbs_m1_cyc_i & wbs_m1_stb_i;

  // Arbitration FSM. The grant is held until the owner drops cyc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
          end else if (req1) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
          end
        end
        GNT0: begin
          if (!wbs_m0_cyc_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        GNT1: begin
          if (!wbs_m1_cyc_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign sel0 = grant_q[0];
  assign sel1 = grant_q[1];
  assign gstb = (sel0 & wbs_m0_stb_i) | (sel1 & wbs_m1_stb_i);

  // AND-OR mux: a zero grant yields an all-zero slave bus.
  assign wbs_s_cyc_o = (sel0 & wbs_m0_cyc_i) | (sel1 & wbs_m1_cyc_i);
  assign wbs_s_stb_o = gstb & ~fire;
  assign wbs_s_we_o  = (sel0 & wbs_m0_we_i) | (sel1 & wbs_m1_we_i);
  assign wbs_s_adr_o = ({32{sel0}} & wbs_m0_adr_i) | ({32{sel1}} & wbs_m1_adr_i);
  assign wbs_s_dat_o = ({32{sel0}} & wbs_m0_dat_i) | ({32{sel1}} & wbs_m1_dat_i);
  assign wbs_s_sel_o = ({4{sel0}} & wbs_m0_sel_i) | ({4{sel1}} & wbs_m1_sel_i);

  // Return path: only the granted master sees ack/data; a watchdog
  // termination overrides whatever the slave drives that cycle.
  assign wbs_m0_ack_o = sel0 & (fire | wbs_s_ack_i);
  assign wbs_m1_ack_o = sel1 & (fire | wbs_s_ack_i);
  assign wbs_m0_dat_o = sel0 ? (fire ? TIMEOUT_DATA : wbs_s_dat_i) : 32'h0;
  assign wbs_m1_dat_o = sel1 ? (fire ? TIMEOUT_DATA : wbs_s_dat_i) : 32'h0;

  assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  // Terminal count is 2^W-2 so that the termination lands on wait cycle
  // 2^W-1 (the first wait cycle sees a count of 0).
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q;
  logic                 in_gnt;

  assign in_gnt = |grant_q;
  assign fire   = in_gnt & gstb & ~wbs_s_ack_i & (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!in_gnt || wbs_s_ack_i || fire) begin
      cnt_d = '0;
    end else if (gstb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_params;

  assign fire          = 1'b0;
  assign timeout_o     = 1'b0;
  assign unused_params = (^TIMEOUT_DATA) ^ TIMEOUT_W[0];
`endif

endmodule

// File: tb/tb_wb_arbiter_2mst_to_1slv.sv
module tb_wb_arbiter_2mst_to_1slv;

  localparam logic [31:0] M0_ADR = 32'h3003_0004;
  localparam logic [31:0] M0_DAT = 32'h1234_5678;
  localparam logic [3:0]  M0_SEL = 4'hF;
  localparam logic        M0_WE  = 1'b1;
  localparam logic [31:0] M1_ADR = 32'h3003_0010;
  localparam logic [31:0] M1_DAT = 32'h55AA_55AA;
  localparam logic [3:0]  M1_SEL = 4'h3;
  localparam logic        M1_WE  = 1'b0;
  localparam logic [31:0] TO_DAT = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_dat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_dat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter_2mst_to_1slv #(.TIMEOUT_W(4), .TIMEOUT_DATA(TO_DAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbs_m0_cyc_i (m0_cyc),
    .wbs_m0_stb_i (m0_stb),
    .wbs_m0_we_i  (m0_we),
    .wbs_m0_adr_i (m0_adr),
    .wbs_m0_dat_i (m0_dat),
    .wbs_m0_sel_i (m0_sel),
    .wbs_m0_dat_o (m0_rdat),
    .wbs_m0_ack_o (m0_ack),
    .wbs_m1_cyc_i (m1_cyc),
    .wbs_m1_stb_i (m1_stb),
    .wbs_m1_we_i  (m1_we),
    .wbs_m1_adr_i (m1_adr),
    .wbs_m1_dat_i (m1_dat),
    .wbs_m1_sel_i (m1_sel),
    .wbs_m1_dat_o (m1_rdat),
    .wbs_m1_ack_o (m1_ack),
    .wbs_s_cyc_o  (s_cyc),
    .wbs_s_stb_o  (s_stb),
    .wbs_s_we_o   (s_we),
    .wbs_s_adr_o  (s_adr),
    .wbs_s_dat_o  (s_wdat),
    .wbs_s_sel_o  (s_sel),
    .wbs_s_dat_i  (s_rdat),
    .wbs_s_ack_i  (s_ack),
    .grant_o      (grant),
    .timeout_o    (timeout)
  );

  typedef struct {
    logic        rst_n;
    logic        c0, s0, c1, s1;
    logic        sack;
    logic [31:0] sdat;
    logic [1:0]  eg;
    logic        escyc, esstb;
    logic        em0ack;
    logic [31:0] em0dat;
    logic        em1ack;
    logic [31:0] em1dat;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c0, input logic s0, input logic c1,
                       input logic s1, input logic sack, input logic [31:0] sdat);
    rst_n  = r;
    m0_cyc = c0;
    m0_stb = s0;
    m1_cyc = c1;
    m1_stb = s1;
    s_ack  = sack;
    s_rdat = sdat;
  endtask

  initial begin
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic        ew;
    int          first;
    int          acks;

    m0_adr = M0_ADR; m0_dat = M0_DAT; m0_sel = M0_SEL; m0_we = M0_WE;
    m1_adr = M1_ADR; m1_dat = M1_DAT; m1_sel = M1_SEL; m1_we = M1_WE;
    drive(1'b0, 0, 0, 0, 0, 0, 32'h0);

    //          rst c0 s0 c1 s1 ack sdat          grant cyc stb m0ack m0dat        m1ack m1dat
    // Single master write from m0
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[1]  = '{1, 1, 1, 0, 0, 0, 32'h0,         2'b01, 1, 1, 0, 32'h0,         0, 32'h0};
    vecs[2]  = '{1, 1, 1, 0, 0, 1, 32'h1111_2222, 2'b01, 1, 1, 1, 32'h1111_2222, 0, 32'h0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    // Reset, then tie: m0 first, IDLE turnaround, then m1
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[6]  = '{1, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[7]  = '{1, 1, 1, 1, 1, 1, 32'hCAFE_0001, 2'b01, 1, 1, 1, 32'hCAFE_0001, 0, 32'h0};
    vecs[8]  = '{1, 0, 0, 1, 1, 0, 32'h0,         2'b01, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[9]  = '{1, 0, 0, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[10] = '{1, 0, 0, 1, 1, 1, 32'hBEEF_0002, 2'b10, 1, 1, 0, 32'h0,         1, 32'hBEEF_0002};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, 32'h0,         0, 32'h0};
    // Next tie alternates back to m0; m0 lowers stb but keeps cyc
    vecs[12] = '{1, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[13] = '{1, 1, 1, 1, 1, 1, 32'h0000_0077, 2'b01, 1, 1, 1, 32'h0000_0077, 0, 32'h0};
    vecs[14] = '{1, 1, 0, 1, 1, 0, 32'h0,         2'b01, 1, 0, 0, 32'h0,         0, 32'h0};
    vecs[15] = '{1, 0, 0, 1, 1, 0, 32'h0,         2'b01, 0, 0, 0, 32'h0,         0, 32'h0};
    // m0 re-requests right away; m1 wins the tie. m1 block of 4 reads.
    vecs[16] = '{1, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[17] = '{1, 1, 1, 1, 1, 1, 32'h0000_00A0, 2'b10, 1, 1, 0, 32'h0,         1, 32'h0000_00A0};
    vecs[18] = '{1, 1, 1, 1, 1, 1, 32'h0000_00A1, 2'b10, 1, 1, 0, 32'h0,         1, 32'h0000_00A1};
    vecs[19] = '{1, 1, 1, 1, 1, 1, 32'h0000_00A2, 2'b10, 1, 1, 0, 32'h0,         1, 32'h0000_00A2};
    vecs[20] = '{1, 1, 1, 1, 1, 1, 32'h0000_00A3, 2'b10, 1, 1, 0, 32'h0,         1, 32'h0000_00A3};
    vecs[21] = '{1, 1, 1, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[22] = '{1, 1, 1, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[23] = '{1, 1, 1, 0, 0, 0, 32'h0,         2'b01, 1, 1, 0, 32'h0,         0, 32'h0};
    // Reset while m0 holds the bus with stb=1; tie afterwards goes to m0
    vecs[24] = '{0, 1, 1, 1, 1, 0, 32'h0,         2'b01, 1, 1, 0, 32'h0,         0, 32'h0};
    vecs[25] = '{1, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[26] = '{1, 1, 1, 1, 1, 0, 32'h0,         2'b01, 1, 1, 0, 32'h0,         0, 32'h0};
    vecs[27] = '{1, 0, 0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, 32'h0,         0, 32'h0};
    vecs[28] = '{1, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset grant", {30'h0, grant}, 32'h0);
    check("reset s_cyc", {31'h0, s_cyc}, 32'h0);
    check("reset s_stb", {31'h0, s_stb}, 32'h0);
    check("reset s_adr", s_adr, 32'h0);
    check("reset m0_ack", {31'h0, m0_ack}, 32'h0);
    check("reset m1_ack", {31'h0, m1_ack}, 32'h0);
    check("reset timeout", {31'h0, timeout}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1,
            vecs[i].sack, vecs[i].sdat);
      case (vecs[i].eg)
        2'b01:   begin ea = M0_ADR; ed = M0_DAT; es = M0_SEL; ew = M0_WE; end
        2'b10:   begin ea = M1_ADR; ed = M1_DAT; es = M1_SEL; ew = M1_WE; end
        default: begin ea = 32'h0;  ed = 32'h0;  es = 4'h0;   ew = 1'b0;  end
      endcase
      @(negedge clk);
      check($sformatf("row%0d grant", i),   {30'h0, grant},  {30'h0, vecs[i].eg});
      check($sformatf("row%0d s_cyc", i),   {31'h0, s_cyc},  {31'h0, vecs[i].escyc});
      check($sformatf("row%0d s_stb", i),   {31'h0, s_stb},  {31'h0, vecs[i].esstb});
      check($sformatf("row%0d s_adr", i),   s_adr,           ea);
      check($sformatf("row%0d s_dat", i),   s_wdat,          ed);
      check($sformatf("row%0d s_sel", i),   {28'h0, s_sel},  {28'h0, es});
      check($sformatf("row%0d s_we", i),    {31'h0, s_we},   {31'h0, ew});
      check($sformatf("row%0d m0_ack", i),  {31'h0, m0_ack}, {31'h0, vecs[i].em0ack});
      check($sformatf("row%0d m0_dat", i),  m0_rdat,         vecs[i].em0dat);
      check($sformatf("row%0d m1_ack", i),  {31'h0, m1_ack}, {31'h0, vecs[i].em1ack});
      check($sformatf("row%0d m1_dat", i),  m1_rdat,         vecs[i].em1dat);
      check($sformatf("row%0d timeout", i), {31'h0, timeout}, 32'h0);
      @(posedge clk);
      #1;
    end

    // Stalled slave: m0 requests, slave never acks.
    drive(1'b1, 1, 1, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("wd req grant", {30'h0, grant}, 32'h0);
    @(posedge clk);
    #1;
`ifdef WB_ARB_TIMEOUT_EN
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m0_ack && first == 0) begin
        first = k;
        check("wd ack data", m0_rdat, TO_DAT);
        check("wd slave stb masked", {31'h0, s_stb}, 32'h0);
        check("wd m1 ack", {31'h0, m1_ack}, 32'h0);
      end
      if (k == 14) check("wd timeout before", {31'h0, timeout}, 32'h0);
      if (k == 16) check("wd timeout set", {31'h0, timeout}, 32'h1);
      if (k == 20) check("wd timeout sticky", {31'h0, timeout}, 32'h1);
      @(posedge clk);
      #1;
    end
    check("wd ack cycle", 32'(first), 32'd15);
`else
    acks = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (m0_ack) acks++;
      @(posedge clk);
      #1;
    end
    check("no-wd ack count", 32'(acks), 32'd0);
    check("no-wd timeout", {31'h0, timeout}, 32'h0);
    check("no-wd grant held", {30'h0, grant}, 32'h1);
`endif

    // Release, then a normal transfer must still work.
    drive(1'b1, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1, 1, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1, 1, 0, 0, 1, 32'h0000_0005);
    @(negedge clk);
    check("post grant", {30'h0, grant}, 32'h1);
    check("post m0_ack", {31'h0, m0_ack}, 32'h1);
    check("post m0_dat", m0_rdat, 32'h0000_0005);
    check("post s_stb", {31'h0, s_stb}, 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    check("post timeout", {31'h0, timeout}, 32'h1);
`else
    check("post timeout", {31'h0, timeout}, 32'h0);
`endif
    @(posedge clk);
    #1;
    drive(1'b1, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
